tgr_mq: RTL

TGR_MQ -- requirements
Module: tgr_mq

---
 rtl/tgr_mq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tgr_mq.sv
// Multi-channel token-bucket traffic gate: per-channel buckets refilled once per slot,
// drained on scheduler grants. Optional macro TGR_DEFICIT_EN allows negative buckets.
module tgr_mq #(
   parameter int CH_NUM   = 4,
   parameter int TOKEN_W  = 16,
   parameter int LEN_W    = 12,
   parameter int OVERHEAD = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       test_stop,
   input  logic                       lau_update_finish,
   input  logic [CH_NUM-1:0]          in_tgr_ch_en,
   input  logic [CH_NUM*LEN_W-1:0]    in_tgr_pkt_len,
   input  logic [CH_NUM*TOKEN_W-1:0]  in_tgr_tb_size,
   input  logic [CH_NUM*TOKEN_W-1:0]  in_tgr_tb_rate,
   input  logic                       in_tgr_slot_shift,
   input  logic                       in_tgr_sel_valid,
   input  logic [3:0]                 in_tgr_sel_id,
   output logic [CH_NUM-1:0]          out_tgr_req,
   output logic                       out_tgr_err
);

   localparam int RW = TOKEN_W + 2;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_e;

   state_e                     state_q, state_d;
   logic                       slot_q, slot_d;
   logic [CH_NUM-1:0][RW-1:0]  rt_q, rt_d;
   logic [CH_NUM-1:0]          req_q, req_d;
   logic                       err_q, err_d;

   logic                       slot_hit;
   logic                       id_bad;
   logic                       id_req;
   logic [CH_NUM-1:0]          grant;
   logic [CH_NUM-1:0][RW-1:0]  cost;
   logic [CH_NUM-1:0][RW-1:0]  size_x;
   logic [CH_NUM-1:0][RW-1:0]  rate_x;
   logic [CH_NUM-1:0][RW-1:0]  sum;
   logic [CH_NUM-1:0][RW-1:0]  nxt;
   logic [CH_NUM-1:0]          req_ok;

   always_comb begin
      state_d = state_q;
      if (test_stop) begin
         state_d = S_INIT;
      end else if (state_q == S_INIT && lau_update_finish) begin
         state_d = S_RUN;
      end
   end

   assign slot_hit = in_tgr_slot_shift ^ slot_q;
   assign slot_d   = in_tgr_slot_shift;

   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         cost[i]   = RW'(in_tgr_pkt_len[i*LEN_W +: LEN_W]) + RW'(OVERHEAD);
         size_x[i] = RW'(in_tgr_tb_size[i*TOKEN_W +: TOKEN_W]);
         rate_x[i] = RW'(in_tgr_tb_rate[i*TOKEN_W +: TOKEN_W]);
         grant[i]  = in_tgr_sel_valid && (in_tgr_sel_id == 4'(i));
         sum[i]    = rt_q[i]
                   + (slot_hit ? rate_x[i] : '0)
                   - (grant[i] ? cost[i] : '0);
`ifdef TGR_DEFICIT_EN
         // Deficit mode: negative balance is carried into later slots.
         if ($signed(sum[i]) > $signed(size_x[i])) begin
            nxt[i] = size_x[i];
         end else begin
            nxt[i] = sum[i];
         end
         req_ok[i] = $signed(rt_q[i]) > $signed(RW'(0));
`else
         if ($signed(sum[i]) < $signed(RW'(0))) begin
            nxt[i] = '0;
         end else if (sum[i] > size_x[i]) begin
            nxt[i] = size_x[i];
         end else begin
            nxt[i] = sum[i];
         end
         req_ok[i] = rt_q[i] >= cost[i];
`endif
      end
   end

   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         rt_d[i]  = '0;
         req_d[i] = 1'b0;
         if (!in_tgr_ch_en[i] || state_d == S_INIT) begin
            rt_d[i] = '0;
         end else if (state_q == S_INIT) begin
            rt_d[i] = (rate_x[i] < size_x[i]) ? rate_x[i] : size_x[i];
         end else begin
            rt_d[i] = nxt[i];
         end
         // A granted channel drops its request for one cycle while its cost lands.
         req_d[i] = (state_q == S_RUN) && !test_stop && in_tgr_ch_en[i]
                  && !grant[i] && req_ok[i];
      end
   end

   always_comb begin
      id_req = 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (in_tgr_sel_id == 4'(i)) begin
            id_req = req_q[i];
         end
      end
      id_bad = {1'b0, in_tgr_sel_id} >= 5'(CH_NUM);
      err_d  = (state_q == S_RUN) && in_tgr_sel_valid && (id_bad || !id_req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         slot_q  <= 1'b0;
         rt_q    <= '0;
         req_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         rt_q    <= rt_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end
   end

   assign out_tgr_req = req_q;
   assign out_tgr_err = err_q;

endmodule
